// File: rtl/mcu_int_arbiter.sv
// mcu_int_arbiter
//   Prioritised interrupt arbiter between the raw interrupt lines and the
//   instruction controller. Rising edges on src_in latch pending bits.
//   Per-source and global enables gate eligibility. The lowest eligible
//   index wins and is presented with its ROM entry vector. The in-service
//   source is tracked through an ack / end-of-interrupt handshake.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous reset, active low
//   src_in      raw interrupt lines (rising edge = request)
//   cfg_we      register write strobe
//   cfg_addr    register select (0 IE, 1 PEND, 2 STAT, 3 VBASE_OFS)
//   cfg_wdata   register write data
//   cfg_rdata   register read data, combinational from cfg_addr
//   irq_req     request to controller
//   irq_id      requesting / in-service source index
//   irq_vector  VEC_BASE + VBASE_OFS + irq_id*VEC_STRIDE (mod 256)
//   irq_ack     controller took the interrupt (one-cycle pulse)
//   irq_eoi     service routine returned (one-cycle pulse)
//
// state   | meaning
// IDLE    | nothing requested or in service
// REQ     | presenting the current winner to the controller
// SERVICE | winner acknowledged, waiting for eoi (no nesting)

module mcu_int_arbiter #(
  parameter int unsigned NSRC       = 4,
  parameter logic [7:0]  VEC_BASE   = 8'd19,
  parameter logic [7:0]  VEC_STRIDE = 8'd16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_in,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [15:0]     cfg_wdata,
  output logic [15:0]     cfg_rdata,
  output logic            irq_req,
  output logic [2:0]      irq_id,
  output logic [7:0]      irq_vector,
  input  logic            irq_ack,
  input  logic            irq_eoi
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      id_q, id_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] ie_q, ie_d;
  logic            ge_q, ge_d;
  logic [7:0]      ofs_q, ofs_d;
  logic [NSRC-1:0] src_d_q, src_d_d;

  logic [NSRC-1:0] src_edge;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] ack_clr;
  logic [2:0]      winner;

  // Not every write-data bit maps to a register field.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      pend_q  <= '0;
      ie_q    <= '0;
      ge_q    <= 1'b0;
      ofs_q   <= '0;
      src_d_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      ie_q    <= ie_d;
      ge_q    <= ge_d;
      ofs_q   <= ofs_d;
      src_d_q <= src_d_d;
    end
  end

  always_comb begin
    src_edge = src_in & ~src_d_q;
    src_d_d  = src_in;
    elig     = pend_q & ie_q & {NSRC{ge_q}};
    w1c      = (cfg_we && (cfg_addr == 2'd1)) ? cfg_wdata[NSRC-1:0] : '0;
  end

  // Fixed priority: scan downwards so the lowest set index is the last write.
  always_comb begin
    winner = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (elig[i]) winner = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ack_clr = '0;
    irq_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_d = ST_REQ;
          id_d    = winner;
        end
      end
      ST_REQ: begin
        // Losing eligibility withdraws the request immediately; an ack
        // arriving in that cycle has nothing valid to acknowledge.
        if (!(|elig)) begin
          state_d = ST_IDLE;
        end else begin
          irq_req = 1'b1;
          if (irq_ack) begin
            state_d = ST_SERVICE;
            for (int i = 0; i < int'(NSRC); i++) begin
              if (id_q == 3'(i)) ack_clr[i] = 1'b1;
            end
          end else begin
            id_d = winner;
          end
        end
      end
      ST_SERVICE: begin
        if (irq_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new edge wins over any clear arriving in the same cycle.
  always_comb begin
    pend_d = (pend_q & ~w1c & ~ack_clr) | src_edge;
    ie_d   = ie_q;
    ge_d   = ge_q;
    ofs_d  = ofs_q;
    if (cfg_we) begin
      case (cfg_addr)
        2'd0: begin
          ie_d = cfg_wdata[NSRC-1:0];
          ge_d = cfg_wdata[15];
        end
        2'd3:    ofs_d = cfg_wdata[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: begin
        cfg_rdata[NSRC-1:0] = ie_q;
        cfg_rdata[15]       = ge_q;
      end
      2'd1: cfg_rdata[NSRC-1:0] = pend_q;
      2'd2: cfg_rdata = {(state_q == ST_SERVICE), 5'b0, state_q, 5'b0, id_q};
      default: cfg_rdata = {8'b0, ofs_q};
    endcase
  end

  assign irq_id     = id_q;
  assign irq_vector = VEC_BASE + ofs_q + ({5'b0, id_q} * VEC_STRIDE);

endmodule
